// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM state encoding, mode codes and decode helpers
// shared by the SPI flash bridge.
package spi_flash_pkg;

   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_FAST = 8'h0B;
   localparam logic [7:0] OP_DOR  = 8'h3B;
   localparam logic [7:0] OP_QOR  = 8'h6B;

   localparam logic [1:0] MODE_IDLE   = 2'd0;
   localparam logic [1:0] MODE_SINGLE = 2'd1;
   localparam logic [1:0] MODE_DUAL   = 2'd2;
   localparam logic [1:0] MODE_QUAD   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_PASS, ST_SINGLE,
      ST_DUAL_WAIT, ST_DUAL_OUT, ST_QUAD_WAIT, ST_QUAD_OUT
   } state_t;

   function automatic state_t decode(input logic [7:0] op, input logic quad_en);
      return (op == OP_READ || op == OP_FAST) ? ST_SINGLE :
             (op == OP_DOR)                   ? ST_DUAL_WAIT :
             (op == OP_QOR && quad_en)        ? ST_QUAD_WAIT : ST_PASS;
   endfunction

   function automatic logic [1:0] mode_of(input state_t s);
      return (s == ST_SINGLE)                          ? MODE_SINGLE :
             (s == ST_DUAL_WAIT || s == ST_DUAL_OUT)   ? MODE_DUAL :
             (s == ST_QUAD_WAIT || s == ST_QUAD_OUT)   ? MODE_QUAD : MODE_IDLE;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: STAGES-deep single-bit synchroniser with asynchronous active-low
// reset to a configurable level.
module spi_sync #(
   parameter int   STAGES  = 3,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ff <= {STAGES{RST_VAL}};
      else        ff <= {ff[STAGES-2:0], d};
   assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_flash_bridge.sv
// spi_flash_bridge: SPI host-to-flash pass-through that snoops the opcode,
// forces IO0 at a set edge and turns IO lines around for dual/quad reads.
module spi_flash_bridge
   import spi_flash_pkg::*;
#(
   parameter int SYNC_STAGES = 3,
   parameter int CNT_W       = 8,
   parameter int FORCE_EDGE  = 13,
   parameter int DUAL_TURN   = 38,
   parameter int QUAD_TURN   = 38,
   parameter int QUAD_EN     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cson,
   input  logic       sclk,
   input  logic [3:0] io_i,
   output logic [3:0] io_o,
   output logic [3:0] io_oe,
   output logic       flash_cs_n,
   output logic       flash_sclk,
   input  logic [3:0] flash_io_i,
   output logic [3:0] flash_io_o,
   output logic [3:0] flash_io_oe,
   output logic [7:0] cmd,
   output logic       cmd_valid,
   output logic [1:0] mode
);
   logic                   cs_s, sclk_s, io0_s, cs_q, sclk_q, armed, at8, force_on;
   logic                   rise, fall, active;
   logic [SYNC_STAGES-1:0] live;
   logic [CNT_W-1:0]       cnt;
   logic [7:0]             sr;
   state_t                 state, state_nx;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs   (.clk, .rst_n, .d(cson),    .q(cs_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (.clk, .rst_n, .d(sclk),    .q(sclk_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_io0  (.clk, .rst_n, .d(io_i[0]), .q(io0_s));

   // a frame already in flight at reset release is ignored until cson has been seen high
   assign rise   = ~sclk_q & sclk_s;
   assign fall   = armed & cs_q & ~cs_s;
   assign active = (state != ST_IDLE) | fall;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {cs_q, sclk_q} <= 2'b11;
         live      <= '0;
         armed     <= 1'b0;
         state     <= ST_IDLE;
         cnt       <= '0;
         sr        <= '0;
         cmd       <= '0;
         cmd_valid <= 1'b0;
         at8       <= 1'b0;
         force_on  <= 1'b0;
      end else begin
         cs_q      <= cs_s;
         sclk_q    <= sclk_s;
         live      <= {live[SYNC_STAGES-2:0], 1'b1};
         armed     <= armed | (live[SYNC_STAGES-1] & cs_s);
         state     <= state_nx;
         at8       <= cnt == CNT_W'(8);
         cmd_valid <= ~cs_s & (cnt == CNT_W'(8)) & ~at8;
         force_on  <= ~cs_s & (cnt == CNT_W'(FORCE_EDGE)) &
                      (state == ST_SINGLE || state == ST_DUAL_WAIT || state == ST_QUAD_WAIT);
         if (cs_s) begin
            cnt <= '0;
            sr  <= '0;
            cmd <= '0;
         end else begin
            if (rise && active) begin
               cnt <= (&cnt) ? cnt : cnt + 1'b1;
               sr  <= {sr[6:0], io0_s};
            end
            if (cnt == CNT_W'(8) && !at8) cmd <= sr;
         end
      end

   always_comb begin
      state_nx = state;
      if (cs_s) state_nx = ST_IDLE;
      else
         case (state)
            ST_IDLE:      state_nx = fall ? ST_CMD : ST_IDLE;
            ST_CMD:       state_nx = (cnt == CNT_W'(8)) ? decode(sr, QUAD_EN != 0) : ST_CMD;
            ST_DUAL_WAIT: state_nx = (cnt >= CNT_W'(DUAL_TURN)) ? ST_DUAL_OUT : ST_DUAL_WAIT;
            ST_QUAD_WAIT: state_nx = (cnt >= CNT_W'(QUAD_TURN)) ? ST_QUAD_OUT : ST_QUAD_WAIT;
            default:      state_nx = state;
         endcase
   end

   assign flash_cs_n  = cson;
   assign flash_sclk  = sclk;
   assign mode        = mode_of(state);
   assign flash_io_o  = {(state == ST_QUAD_WAIT) ? io_i[3:2] : 2'b11, io_i[1], force_on | io_i[0]};
   assign flash_io_oe = (state == ST_DUAL_OUT) ? 4'b1100 : (state == ST_QUAD_OUT) ? 4'b0000 : 4'b1101;
   assign io_oe       = (state == ST_DUAL_OUT) ? 4'b0011 : (state == ST_QUAD_OUT) ? 4'b1111 : 4'b0010;
   assign io_o        = (state == ST_DUAL_OUT) ? {2'b00, flash_io_i[1:0]} :
                        (state == ST_QUAD_OUT) ? flash_io_i : {2'b00, flash_io_i[1], 1'b0};
endmodule

// File: tb/tb_spi_flash_bridge.sv
// tb_spi_flash_bridge: directed frames (single/dual/quad/unknown opcodes, release,
// async reset, saturation) against hand-computed expectations.
module tb_spi_flash_bridge;
   logic       clk = 0, rst_n, cson, sclk;
   logic [3:0] io_i, flash_io_i;
   logic [3:0] io_o, io_oe, flash_io_o, flash_io_oe;
   logic       flash_cs_n, flash_sclk, cmd_valid;
   logic [7:0] cmd;
   logic [1:0] mode;
   logic [3:0] nq_io_o, nq_io_oe, nq_flash_io_o, nq_flash_io_oe;
   logic       nq_flash_cs_n, nq_flash_sclk, nq_cmd_valid;
   logic [7:0] nq_cmd;
   logic [1:0] nq_mode;

   int n_chk = 0, n_err = 0;
   int cv_cnt, force_cyc, oe_bad, mirror_bad, rises, first_turn;

   always #5 clk = ~clk;

   spi_flash_bridge dut (
      .clk, .rst_n, .cson, .sclk, .io_i, .io_o, .io_oe, .flash_cs_n, .flash_sclk,
      .flash_io_i, .flash_io_o, .flash_io_oe, .cmd, .cmd_valid, .mode);

   spi_flash_bridge #(.QUAD_EN(0)) dut_nq (
      .clk, .rst_n, .cson, .sclk, .io_i, .io_o(nq_io_o), .io_oe(nq_io_oe),
      .flash_cs_n(nq_flash_cs_n), .flash_sclk(nq_flash_sclk), .flash_io_i,
      .flash_io_o(nq_flash_io_o), .flash_io_oe(nq_flash_io_oe), .cmd(nq_cmd),
      .cmd_valid(nq_cmd_valid), .mode(nq_mode));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sample();
      if (cmd_valid) cv_cnt++;
      if (flash_io_o[0] != io_i[0]) force_cyc++;
      if (io_oe != 4'b0010) oe_bad++;
      if (io_o[1] != flash_io_i[1]) mirror_bad++;
      if (io_oe == 4'b0011 && first_turn < 0) first_turn = rises;
   endtask

   task automatic start();
      @(negedge clk);
      cson = 1'b0;
      #1 chk("cs_passthru", flash_cs_n, 1'b0);
      {cv_cnt, force_cyc, oe_bad, mirror_bad, rises} = '0;
      first_turn = -1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         io_i[0] = b[7 - (i % 8)];
         flash_io_i[1] = ~flash_io_i[1];
         sclk = 1'b0;
         repeat (4) begin @(negedge clk); sample(); end
         sclk = 1'b1;
         rises++;
         repeat (4) begin @(negedge clk); sample(); end
      end
      sclk = 1'b0;
   endtask

   task automatic stop();
      @(negedge clk);
      cson = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      int waited;
      rst_n = 0; cson = 1; sclk = 0; io_i = 0; flash_io_i = 0;
      #1;
      chk("rst_io_oe", io_oe, 4'b0010);
      chk("rst_flash_oe", flash_io_oe, 4'b1101);
      chk("rst_io_o0", io_o[0], 1'b0);
      chk("rst_flash_o32", flash_io_o[3:2], 2'b11);
      chk("rst_cmd", cmd, 8'h00);
      chk("rst_cmd_valid", cmd_valid, 1'b0);
      chk("rst_mode", mode, 2'd0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (8) @(negedge clk);

      // single read
      start();
      send(8'h03, 8); send(8'h00, 24);
      chk("rd_cmd", cmd, 8'h03);
      chk("rd_mode", mode, 2'd1);
      chk("rd_cv_once", cv_cnt, 1);
      chk("rd_force_cyc", force_cyc, 8);
      chk("rd_oe_stable", oe_bad, 0);
      stop();
      chk("rd_mode_rel", mode, 2'd0);

      // dual output read
      start();
      send(8'h3B, 8); send(8'h00, 40);
      chk("dor_turn_edge", first_turn, 38);
      chk("dor_cmd", cmd, 8'h3B);
      chk("dor_mode", mode, 2'd2);
      chk("dor_flash_oe", flash_io_oe, 4'b1100);
      flash_io_i = 4'b0101;
      #1 chk("dor_io_o_a", io_o[1:0], 2'b01);
      flash_io_i = 4'b1010;
      #1 chk("dor_io_o_b", io_o[1:0], 2'b10);
      stop();

      // quad output read, both with and without quad support
      start();
      send(8'h6B, 8); send(8'h00, 8);
      io_i[3:2] = 2'b01;
      #1;
      chk("qor_wp_hold", flash_io_o[3:2], 2'b01);
      chk("nq_wp_hold", nq_flash_io_o[3:2], 2'b11);
      io_i[3:2] = 2'b00;
      send(8'h00, 32);
      flash_io_i = 4'b1001;
      #1;
      chk("qor_io_oe", io_oe, 4'b1111);
      chk("qor_flash_oe", flash_io_oe, 4'b0000);
      chk("qor_io_o", io_o, 4'b1001);
      chk("qor_mode", mode, 2'd3);
      chk("nq_mode", nq_mode, 2'd0);
      chk("nq_io_oe", nq_io_oe, 4'b0010);
      chk("nq_flash_oe", nq_flash_io_oe, 4'b1101);
      chk("nq_cmd", nq_cmd, 8'h6B);
      stop();

      // unknown opcode passes through untouched
      start();
      send(8'h9F, 8); send(8'h00, 24);
      chk("jedec_cmd", cmd, 8'h9F);
      chk("jedec_mode", mode, 2'd0);
      chk("jedec_force", force_cyc, 0);
      chk("jedec_mirror", mirror_bad, 0);
      stop();

      // chip-select release during DUAL_OUT
      start();
      send(8'h3B, 8); send(8'h00, 40);
      chk("rel_pre_oe", io_oe, 4'b0011);
      @(negedge clk);
      cson = 1'b1;
      waited = 0;
      while (waited < 10 && !(io_oe == 4'b0010 && flash_io_oe == 4'b1101)) begin
         @(negedge clk);
         waited++;
      end
      chk("rel_latency_ok", waited <= 4, 1'b1);
      chk("rel_cmd_clr", cmd, 8'h00);
      repeat (8) @(negedge clk);

      // asynchronous reset during DUAL_OUT, then ignore the frame in flight
      start();
      send(8'h3B, 8); send(8'h00, 40);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_io_oe", io_oe, 4'b0010);
      chk("arst_flash_oe", flash_io_oe, 4'b1101);
      chk("arst_mode", mode, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      {cv_cnt, force_cyc} = '0;
      send(8'hFF, 10);
      chk("inflight_cv", cv_cnt, 0);
      chk("inflight_mode", mode, 2'd0);
      stop();

      start();
      send(8'h0B, 8); send(8'h00, 32);
      chk("fast_cmd", cmd, 8'h0B);
      chk("fast_mode", mode, 2'd1);
      chk("fast_cv_once", cv_cnt, 1);
      chk("fast_force_cyc", force_cyc, 8);
      stop();

      // counter saturation with cson held low
      start();
      send(8'h3B, 8); send(8'h00, 292);
      chk("sat_cnt", dut.cnt, 8'd255);
      chk("sat_mode", mode, 2'd2);
      chk("sat_io_oe", io_oe, 4'b0011);
      chk("sat_cmd", cmd, 8'h3B);
      stop();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
